// File: rtl/demux4_reg.sv
// rtl/demux4_reg.sv - registered 1-to-4 demultiplexer with per-slot valid/ready (optional counters: DEMUX4_REG_CNT_EN)
module demux4_reg #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [WIDTH-1:0] In_Data,
    input  logic [1:0]       In_Sel,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out0,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [3:0]       Out_Valid,
    input  logic [3:0]       Out_Ready,
    output logic [15:0]      Cnt0,
    output logic [15:0]      Cnt1,
    output logic [15:0]      Cnt2,
    output logic [15:0]      Cnt3
);

    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       drain;
    logic [3:0]       load;
    logic             in_ready;

    // Handshake decode: a slot can take a word when empty or emptying this cycle.
    always_comb begin
        drain    = valid_q & Out_Ready;
        in_ready = ~valid_q[In_Sel] | Out_Ready[In_Sel];
        load     = 4'b0000;
        if (In_Valid && in_ready) begin
            load = 4'b0001 << In_Sel;
        end
    end

    // Next slot state: load wins over drain so drain+load keeps the slot full.
    always_comb begin
        valid_d = (valid_q & ~drain) | load;
        for (int i = 0; i < 4; i++) begin
            data_d[i] = load[i] ? In_Data : data_q[i];
        end
    end

    // Slot registers; reset discards every held word immediately.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign In_Ready  = in_ready;
    assign Out_Valid = valid_q;
    assign Out0      = data_q[0];
    assign Out1      = data_q[1];
    assign Out2      = data_q[2];
    assign Out3      = data_q[3];

`ifdef DEMUX4_REG_CNT_EN
    logic [15:0] cnt_q [4];
    logic [15:0] cnt_d [4];

    // Per-slot accepted-word counters, wrapping at 16 bits.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i] + {15'd0, load[i]};
        end
    end

    // Counter registers, cleared only by reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign Cnt0 = cnt_q[0];
    assign Cnt1 = cnt_q[1];
    assign Cnt2 = cnt_q[2];
    assign Cnt3 = cnt_q[3];
`else
    assign Cnt0 = 16'd0;
    assign Cnt1 = 16'd0;
    assign Cnt2 = 16'd0;
    assign Cnt3 = 16'd0;
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// tb/tb_demux4_reg.sv - directed self-checking bench for demux4_reg (expects counters only with DEMUX4_REG_CNT_EN)
module tb_demux4_reg;

    localparam int WIDTH = 32;

    logic             Clk;
    logic             Rst_n;
    logic [WIDTH-1:0] In_Data;
    logic [1:0]       In_Sel;
    logic             In_Valid;
    logic             In_Ready;
    logic [WIDTH-1:0] Out0, Out1, Out2, Out3;
    logic [3:0]       Out_Valid;
    logic [3:0]       Out_Ready;
    logic [15:0]      Cnt0, Cnt1, Cnt2, Cnt3;

    int n_total;
    int n_pass;

    demux4_reg #(.WIDTH(WIDTH)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .In_Data(In_Data), .In_Sel(In_Sel), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out0(Out0), .Out1(Out1), .Out2(Out2), .Out3(Out3),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Cnt0(Cnt0), .Cnt1(Cnt1), .Cnt2(Cnt2), .Cnt3(Cnt3)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef DEMUX4_REG_CNT_EN
        return v;
`else
        return 32'd0 + (v & 32'd0);
`endif
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        Rst_n     = 1'b0;
        In_Data   = '0;
        In_Sel    = 2'd0;
        In_Valid  = 1'b0;
        Out_Ready = 4'b0000;
        #3;
        chk("rst_valid", Out_Valid, 4'b0000);
        chk("rst_out0", Out0, 0);
        chk("rst_out3", Out3, 0);
        chk("rst_cnt0", Cnt0, 0);
        chk("rst_cnt3", Cnt3, 0);
        chk("rst_in_ready", In_Ready, 1);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Single word to slot 2
        In_Valid = 1'b1; In_Sel = 2'd2; In_Data = 32'hDEADBEEF;
        #1;
        chk("single_ready0", In_Ready, 1);
        tick();
        chk("single_valid", Out_Valid, 4'b0100);
        chk("single_out2", Out2, 32'hDEADBEEF);
        chk("single_ready1", In_Ready, 0);
        chk("single_cnt2", Cnt2, cexp(1));
        In_Valid = 1'b0; Out_Ready = 4'b0100;
        tick();
        Out_Ready = 4'b0000;
        #1;
        chk("single_drained", Out_Valid, 4'b0000);
        chk("single_d_holds", Out2, 32'hDEADBEEF);

        // Back-pressure on slot 1
        In_Valid = 1'b1; In_Sel = 2'd1; In_Data = 32'h11;
        tick();
        In_Data = 32'h22;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("bp_ready", In_Ready, 0);
            chk("bp_out1", Out1, 32'h11);
            chk("bp_valid", Out_Valid, 4'b0010);
            tick();
        end
        Out_Ready = 4'b0010;
        #1;
        chk("bp_release_ready", In_Ready, 1);
        tick();
        In_Valid = 1'b0; Out_Ready = 4'b0000;
        #1;
        chk("bp_out1_new", Out1, 32'h22);
        chk("bp_valid_new", Out_Valid, 4'b0010);
        chk("bp_cnt1", Cnt1, cexp(2));
        Out_Ready = 4'b0010;
        tick();
        Out_Ready = 4'b0000;

        // Simultaneous drain and load
        Out_Ready = 4'b1111;
        In_Valid = 1'b1; In_Sel = 2'd0; In_Data = 32'h1;
        #1;
        chk("tp_ready_w1", In_Ready, 1);
        tick();
        In_Sel = 2'd0; In_Data = 32'h2;
        #1;
        chk("tp_out0_1", Out0, 32'h1);
        chk("tp_valid_1", Out_Valid, 4'b0001);
        chk("tp_ready_w2", In_Ready, 1);
        tick();
        In_Sel = 2'd3; In_Data = 32'h3;
        #1;
        chk("tp_out0_2", Out0, 32'h2);
        chk("tp_valid_2", Out_Valid, 4'b0001);
        chk("tp_ready_w3", In_Ready, 1);
        tick();
        In_Sel = 2'd3; In_Data = 32'h4;
        #1;
        chk("tp_out3_3", Out3, 32'h3);
        chk("tp_valid_3", Out_Valid, 4'b1000);
        chk("tp_ready_w4", In_Ready, 1);
        tick();
        In_Valid = 1'b0;
        #1;
        chk("tp_out3_4", Out3, 32'h4);
        chk("tp_valid_4", Out_Valid, 4'b1000);
        tick();
        chk("tp_valid_end", Out_Valid, 4'b0000);
        chk("tp_cnt0", Cnt0, cexp(2));
        chk("tp_cnt3", Cnt3, cexp(2));

        // Independent slots
        Out_Ready = 4'b0000;
        In_Valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            In_Sel  = 2'(i);
            In_Data = 32'hA0 + 32'(i);
            tick();
        end
        In_Valid = 1'b0;
        #1;
        chk("ind_full", Out_Valid, 4'b1111);
        Out_Ready = 4'b1010;
        tick();
        Out_Ready = 4'b0000;
        #1;
        chk("ind_valid", Out_Valid, 4'b0101);
        chk("ind_out0", Out0, 32'hA0);
        chk("ind_out2", Out2, 32'hA2);
        chk("ind_cnt1", Cnt1, cexp(3));
        chk("ind_cnt3", Cnt3, cexp(3));

        // Mid-cycle reset with words held
        @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        chk("mrst_valid", Out_Valid, 4'b0000);
        chk("mrst_out0", Out0, 0);
        chk("mrst_cnt0", Cnt0, 0);
        chk("mrst_cnt3", Cnt3, 0);
        chk("mrst_ready", In_Ready, 1);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Counter wrap on slot 3 under full-throughput streaming
        Out_Ready = 4'b1111;
        In_Valid = 1'b1; In_Sel = 2'd3;
        for (int n = 1; n <= 32'h10001; n++) begin
            In_Data = 32'(n);
            tick();
            if (n == 32'hFFFF) chk("wrap_ffff", Cnt3, cexp(32'hFFFF));
            if (n == 32'h10000) chk("wrap_zero", Cnt3, cexp(0));
        end
        In_Valid = 1'b0;
        #1;
        chk("wrap_one", Cnt3, cexp(1));
        chk("wrap_last", Out3, 32'h10001);
        chk("wrap_cnt0", Cnt0, 0);

        @(posedge Clk);
        #4;
        Rst_n = 1'b0;
        #1;
        chk("mrst2_cnt3", Cnt3, 0);
        chk("mrst2_valid", Out_Valid, 4'b0000);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/demux4_reg.md
# demux4_reg

Registered 1-to-4 demultiplexer with per-output valid/ready handshakes, the distribution-side counterpart of the core's 4:1 selector. It accepts one data word per cycle on a single input stream and steers it, according to a 2-bit select presented with the word, into one of four single-entry output registers. Each output is held until its consumer takes it. It sits between a single producer, such as a writeback or forwarding source, and up to four independent consumers.

## Interface
Parameters:
- WIDTH, 32: data width of the input and of each output.

Ports:
- Clk, input, 1: single clock; all state updates on the rising edge.
- Rst_n, input, 1: reset, asynchronous and active-low.
- In_Data, input, WIDTH: word to route.
- In_Sel, input, 2: destination index 0..3; qualified by In_Valid.
- In_Valid, input, 1: producer has a word.
- In_Ready, output, 1: block accepts the word this cycle.
- Out0..Out3, output, WIDTH each: output slot data registers.
- Out_Valid, output, 4: bit i means slot i holds a word.
- Out_Ready, input, 4: bit i means consumer i takes slot i this cycle.
- Cnt0..Cnt3, output, 16 each: per-slot accepted-word counters (see Configuration).

## Operation
- Each slot i has two pieces of state: V[i] (drives Out_Valid[i]) and D[i] (drives Outi).
- Drain i: V[i] & Out_Ready[i].
- In_Ready = ~V[In_Sel] | Out_Ready[In_Sel].
  - In_Ready is combinational from In_Sel, V and Out_Ready.
  - In_Ready does not depend on In_Valid.
- Accept: In_Valid & In_Ready. On accept, slot s = In_Sel:
  - D[s] <= In_Data.
  - V[s] <= 1.
- Slot i, per cycle:
  - Load with no drain: V <= 1, D loaded.
  - Drain with no load: V <= 0, D holds its value.
  - Drain and load in the same cycle: V stays 1, D takes the new word. This gives full throughput.
  - Neither: hold.
- Slots are independent.
  - Draining slot j does not affect slot i.
  - Any subset of the four slots may drain in the same cycle.
- At most one slot loads per cycle.
- If In_Valid is asserted and the selected slot is full and not draining:
  - In_Ready = 0 and nothing is loaded.
  - The producer must hold In_Data and In_Sel stable until accepted.
- Out_Ready[i] while V[i] = 0 has no effect.
- D[i] is only meaningful while V[i] = 1.

## Timing
- Reset (Rst_n low, asynchronous):
  - Out_Valid = 4'b0000.
  - Out0..Out3 = 0.
  - Cnt0..Cnt3 = 0.
  - In_Ready = 1 while in reset.
- Reset asserted mid-operation discards every held word. Consumers see Out_Valid drop immediately, not at the next edge.
- Latency: a word accepted at edge N appears on Outs with Out_Valid[s] = 1 after edge N, i.e. 1 cycle.
- Throughput: 1 word per cycle sustained to a single slot if its consumer holds Out_Ready = 1. The same holds when rotating across slots.
- Output data and valid are registered. No combinational path exists from In_* to Out*.
- The only combinational path is Out_Ready/In_Sel to In_Ready.

## Configuration
- Macro DEMUX4_REG_CNT_EN.
- Defined:
  - Cnt[s] increments by 1 on every accepted word routed to slot s.
  - Counters are 16-bit and wrap from 0xFFFF to 0x0000.
  - Counters are cleared only by reset.
- Undefined:
  - Cnt0..Cnt3 are constant 0 and no counter flops are built.
  - Ports remain present.

## Test plan
- Reset release, then a single word:
  - Stimulus: deassert Rst_n; In_Valid = 1, In_Sel = 2, In_Data = 0xDEADBEEF, Out_Ready = 0.
  - Response: one cycle later Out_Valid = 4'b0100 and Out2 = 0xDEADBEEF. The next cycle In_Ready = 0 while In_Sel stays 2.
- Back-pressure hold:
  - Stimulus: slot 1 full with 0x11, Out_Ready[1] = 0, producer presents 0x22 to Sel = 1 for 3 cycles.
  - Response: In_Ready = 0 throughout and Out1 stays 0x11.
  - Then: raise Out_Ready[1]. In that cycle In_Ready = 1, and the next cycle Out1 = 0x22 with Out_Valid[1] = 1.
- Simultaneous drain and load:
  - Stimulus: Out_Ready = 4'b1111, stream 0x1, 0x2, 0x3, 0x4 with Sel = 0, 0, 3, 3.
  - Response: In_Ready stays 1 for all four words. Out0 shows 0x1 then 0x2; Out3 shows 0x3 then 0x4; each is valid for exactly one cycle.
- Independent slots:
  - Stimulus: fill all four slots with 0xA0..0xA3, then Out_Ready = 4'b1010 for one cycle.
  - Response: Out_Valid = 4'b0101, and Out0 and Out2 are unchanged.
- Mid-operation reset and counters (DEMUX4_REG_CNT_EN defined):
  - Stimulus: accept 0x10001 words to slot 3.
  - Response: Cnt3 = 1, because the count wraps.
  - Then: pulse Rst_n low mid-cycle. Out_Valid = 0 and Cnt0..Cnt3 = 0 asynchronously.
  - Without the macro, Cnt3 reads 0 throughout.
